fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 16'h0000, fetch address loaded at reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 stall  input  1  high: no new fetch starts.
REQ-005 redirect  input  1  high: replace fetch address, cancel in-flight fetch.
REQ-006 redirect_pc  input  16  new fetch address, valid when redirect=1.
REQ-007 mem_req  output  1  read request to instruction memory.
REQ-008 mem_addr  output  16  word address of request.
REQ-009 mem_ready  input  1  memory accepts request this cycle.
REQ-010 mem_rvalid  input  1  read data valid this cycle.
REQ-011 mem_rdata  input  16  read data.
REQ-012 instr  output  16  last fetched instruction, data input of the downstream 16-bit register.
REQ-013 ir_write  output  1  one-cycle pulse, drives the downstream register writeEnable.
REQ-014 pc  output  16  word address of instr.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DRAIN; internal 16-bit register fetch_pc.
REQ-017 IDLE: stall=0 -> REQ next cycle; stall=1 -> stay IDLE.
REQ-018 mem_req SHALL be 1 exactly when state=REQ; mem_addr SHALL equal fetch_pc and stay stable while mem_req=1.
REQ-019 REQ: mem_ready=1 -> WAIT; mem_ready=0 -> stay REQ; stall ignored in REQ, WAIT and DRAIN.
REQ-020 WAIT: mem_rvalid=1 -> next edge instr<=mem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+1, ir_write=1 for one cycle, state -> IDLE.
REQ-021 fetch_pc increment SHALL be 16-bit modulo: 16'hFFFF+1 = 16'h0000.
REQ-022 ir_write SHALL be 0 in every cycle not immediately following an accepted response; instr and pc SHALL hold otherwise.
REQ-023 Minimum latency: IDLE with stall=0 at edge N, mem_ready=1 at N+1, mem_rvalid=1 at N+2 -> ir_write=1 during cycle N+3.
REQ-024 redirect=1 in any state: fetch_pc<=redirect_pc at next edge; redirect has priority over the +1 increment.
REQ-025 redirect in IDLE -> IDLE (REQ if stall=0); redirect in REQ with mem_ready=0 -> request dropped, IDLE.
REQ-026 redirect in REQ with mem_ready=1 same cycle -> DRAIN.
REQ-027 redirect in WAIT with mem_rvalid=0 -> DRAIN; redirect with mem_rvalid=1 -> response discarded, IDLE, ir_write stays 0.
REQ-028 DRAIN: wait for mem_rvalid=1, discard data (no ir_write, instr/pc unchanged), then IDLE; redirect in DRAIN updates fetch_pc, stays DRAIN.
REQ-029 mem_rvalid outside WAIT/DRAIN SHALL be ignored.
REQ-030 At most one request SHALL be outstanding at any time.

Reset
REQ-031 rst_n=0 at a rising edge SHALL set state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, instr=16'h0000, ir_write=0; mem_req=0 and busy=0 follow from IDLE.
REQ-032 Reset SHALL override all inputs, including redirect and mem_rvalid, in the same cycle.
REQ-033 Reset mid-fetch SHALL abandon the outstanding request without draining; responses arriving later in IDLE SHALL be ignored.

Verification
REQ-034 Reset, stall=0, memory ready=1, rvalid one cycle after accept, data=addr^16'hA5A5 -> ir_write every 3 cycles, instr=16'hA5A5,16'hA5A4,..., pc=0,1,2.
REQ-035 RESET_PC=16'hFFFF, two fetches -> pc=16'hFFFF then 16'h0000; mem_addr wraps.
REQ-036 mem_ready held 0 for 4 cycles -> mem_req=1, mem_addr constant for 4 cycles, no ir_write; accept on cycle 5 -> normal completion.
REQ-037 redirect_pc=16'h0040 in WAIT, rvalid 2 cycles later -> data discarded, no ir_write, next mem_addr=16'h0040.
REQ-038 redirect with mem_rvalid same cycle in WAIT -> no ir_write, instr unchanged, next mem_addr=redirect_pc.
REQ-039 stall=1 in IDLE for 5 cycles -> mem_req=0, busy=0; stall=1 raised in WAIT -> fetch still completes with ir_write pulse.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
//   mem_req    : read request, held until accepted
//   mem_addr   : word address of the request, stable while mem_req=1
//   mem_ready  : memory accepts the request this cycle
//   mem_rvalid : read data valid this cycle
//   mem_rdata  : read data
// Modports: master (fetch unit side), slave (memory side).
interface fetch_unit_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit.
// Fetches one 16-bit word per request from instruction memory and presents it to a
// downstream instruction register with a one-cycle write pulse. A redirect replaces
// the fetch address and cancels any in-flight fetch; a cancelled request whose
// response is still owed is drained and its data thrown away.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   stall        : blocks starting a new fetch (only consulted in IDLE)
//   redirect     : load redirect_pc as the next fetch address, cancel current fetch
//   redirect_pc  : new fetch address
//   mem          : instruction-memory bus (master side)
//   instr        : last fetched instruction
//   ir_write     : one-cycle pulse when instr/pc are updated
//   pc           : word address of instr
//   busy         : high whenever the FSM is not idle
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [15:0]        redirect_pc,
  fetch_unit_if.master       mem,
  output logic [15:0]        instr,
  output logic               ir_write,
  output logic [15:0]        pc,
  output logic               busy
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrain
  } state_e;

  state_e      state_q;
  logic [15:0] fetch_pc_q;
  logic [15:0] instr_q;
  logic [15:0] pc_q;
  logic        ir_write_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Abandons any outstanding request outright; a late response lands in IDLE
      // and is ignored there.
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      instr_q    <= 16'h0000;
      pc_q       <= RESET_PC;
      ir_write_q <= 1'b0;
    end else begin
      ir_write_q <= 1'b0;
      if (redirect) begin
        fetch_pc_q <= redirect_pc;
      end
      unique case (state_q)
        StIdle: begin
          if (!stall) begin
            state_q <= StReq;
          end
        end
        StReq: begin
          if (redirect) begin
            // Accepted request still owes a response, so it must be drained.
            state_q <= mem.mem_ready ? StDrain : StIdle;
          end else if (mem.mem_ready) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (redirect) begin
            state_q <= mem.mem_rvalid ? StIdle : StDrain;
          end else if (mem.mem_rvalid) begin
            instr_q    <= mem.mem_rdata;
            pc_q       <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + 16'd1;
            ir_write_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        StDrain: begin
          if (mem.mem_rvalid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem.mem_req  = (state_q == StReq);
  assign mem.mem_addr = fetch_pc_q;
  assign instr        = instr_q;
  assign pc           = pc_q;
  assign ir_write     = ir_write_q;
  assign busy         = (state_q != StIdle);

endmodule
